// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory request/ack, downstream valid/ready
// and the start/halt/branch controls of the PC sequencer.
interface pc_fetch_ctrl_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);
  logic               start;
  logic               halt_req;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               instr_ready;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic [PC_W-1:0]    pc_out;
  logic               halted;

  modport master (
    input  start, halt_req, imem_ack, imem_rdata, instr_ready, branch_taken, branch_target,
    output imem_req, imem_addr, instr_out, instr_valid, pc_out, halted
  );

  modport slave (
    output start, halt_req, imem_ack, imem_rdata, instr_ready, branch_taken, branch_target,
    input  imem_req, imem_addr, instr_out, instr_valid, pc_out, halted
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer: fetches one word at a time from instruction memory
// and hands it downstream, advancing or redirecting the PC on each acceptance.
module pc_fetch_ctrl #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  pc_fetch_ctrl_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_e;

  state_e             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               req_q;
  logic               vld_q;
  logic               halted_q;
  logic               halt_pend_q;

  logic [PC_W-1:0]    pc_d;
  logic               hs;

  assign hs = vld_q & bus.instr_ready;

  // Branch inputs only matter on the handshake cycle, where pc_d is consumed.
  always_comb begin
    pc_d = bus.branch_taken ? bus.branch_target : pc_q + PC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      req_q       <= 1'b0;
      vld_q       <= 1'b0;
      halted_q    <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (bus.halt_req) halt_pend_q <= 1'b1;
          if (bus.imem_ack) begin
            instr_q <= bus.imem_rdata;
            req_q   <= 1'b0;
            vld_q   <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (hs) begin
            pc_q        <= pc_d;
            vld_q       <= 1'b0;
            halt_pend_q <= 1'b0;
            if (bus.halt_req || halt_pend_q) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end
          end else if (bus.halt_req) begin
            halt_pend_q <= 1'b1;
          end
        end
        HALTED: begin
          if (bus.start) begin
            state_q  <= REQ;
            req_q    <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.pc_out      = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = vld_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a flag-level model of the fetch sequencer.
module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.PC_W(8), .INSTR_W(16)) bus ();

  pc_fetch_ctrl #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [256];
  assign bus.imem_rdata = mem[bus.imem_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the outputs must be after each edge.
  logic        m_on = 1'b0;
  logic        m_req, m_vld, m_hlt, m_pend;
  logic [7:0]  m_pc;
  logic [15:0] m_instr;

  always @(posedge clk) begin
    if (rst) begin
      m_on <= 1'b1; m_req <= 1'b0; m_vld <= 1'b0; m_hlt <= 1'b0;
      m_pend <= 1'b0; m_pc <= 8'h00; m_instr <= 16'h0;
    end else if (m_on) begin
      if (m_req) begin
        if (bus.halt_req) m_pend <= 1'b1;
        if (bus.imem_ack) begin
          m_instr <= mem[m_pc];
          m_req   <= 1'b0;
          m_vld   <= 1'b1;
        end
      end else if (m_vld) begin
        if (bus.instr_ready) begin
          m_pc   <= bus.branch_taken ? bus.branch_target : m_pc + 8'd1;
          m_vld  <= 1'b0;
          m_pend <= 1'b0;
          if (bus.halt_req || m_pend) m_hlt <= 1'b1;
          else                        m_req <= 1'b1;
        end else if (bus.halt_req) begin
          m_pend <= 1'b1;
        end
      end else if (bus.start) begin
        m_req <= 1'b1;
        m_hlt <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("imem_req",    bus.imem_req,    m_req);
      chk("imem_addr",   bus.imem_addr,   m_pc);
      chk("pc_out",      bus.pc_out,      m_pc);
      chk("instr_valid", bus.instr_valid, m_vld);
      chk("instr_out",   bus.instr_out,   m_instr);
      chk("halted",      bus.halted,      m_hlt);
    end
  end

  task automatic wait_req();
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_req_timeout", bus.imem_req, 1'b1);
  endtask

  task automatic fetch(input logic br, input logic [7:0] tgt, output logic [7:0] addr);
    wait_req();
    addr = bus.imem_addr;
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack      = 1'b0;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    @(negedge clk);
    bus.branch_taken  = 1'b0;
  endtask

  initial begin
    logic [7:0]  a;
    logic [7:0]  pc0;
    logic [15:0] i0;

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    bus.start = 1'b0; bus.halt_req = 1'b0; bus.imem_ack = 1'b0;
    bus.instr_ready = 1'b1; bus.branch_taken = 1'b0; bus.branch_target = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_pc", bus.pc_out, 8'h00);
    chk("rst_halted", bus.halted, 1'b0);
    chk("rst_instr", bus.instr_out, 16'h0);

    // Sequential fetch with one-cycle memory latency
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_req();
      chk("seq_addr", bus.imem_addr, i);
      @(negedge clk);
      bus.imem_ack = 1'b1;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      chk("seq_valid", bus.instr_valid, 1'b1);
      chk("seq_instr", bus.instr_out, mem[i]);
    end

    // Wrap from 0xFF to 0x00
    fetch(1'b1, 8'hFF, a);
    fetch(1'b0, 8'h00, a);
    chk("wrap_from", a, 8'hFF);
    wait_req();
    chk("wrap_addr", bus.imem_addr, 8'h00);

    // Branch redirect from pc 0x05
    fetch(1'b1, 8'h05, a);
    fetch(1'b1, 8'h40, a);
    chk("br_from", a, 8'h05);
    wait_req();
    chk("br_addr", bus.imem_addr, 8'h40);

    // Backpressure with a halt pulse during the stall
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.instr_ready = 1'b0;
    pc0 = bus.pc_out;
    i0  = bus.instr_out;
    for (int k = 0; k < 4; k++) begin
      bus.halt_req = (k == 1);
      @(negedge clk);
      chk("stall_pc", bus.pc_out, pc0);
      chk("stall_instr", bus.instr_out, i0);
      chk("stall_valid", bus.instr_valid, 1'b1);
    end
    bus.halt_req = 1'b0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("halt_halted", bus.halted, 1'b1);
    chk("halt_req_low", bus.imem_req, 1'b0);
    repeat (2) @(negedge clk);
    chk("halt_hold", bus.halted, 1'b1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("resume_req", bus.imem_req, 1'b1);
    chk("resume_addr", bus.imem_addr, pc0 + 8'd1);
    chk("resume_halted", bus.halted, 1'b0);

    // Slow memory, then reset while the request is outstanding
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("slow_req", bus.imem_req, 1'b1);
      chk("slow_addr", bus.imem_addr, pc0 + 8'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_req", bus.imem_req, 1'b0);
    chk("mid_rst_valid", bus.instr_valid, 1'b0);
    chk("mid_rst_pc", bus.pc_out, 8'h00);
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("stray_req", bus.imem_req, 1'b0);
    chk("stray_valid", bus.instr_valid, 1'b0);
    chk("stray_pc", bus.pc_out, 8'h00);

    // Same-cycle acknowledge on the first request cycle
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("sc_req", bus.imem_req, 1'b1);
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("sc_valid", bus.instr_valid, 1'b1);
    chk("sc_noreq", bus.imem_req, 1'b0);
    chk("sc_instr", bus.instr_out, mem[0]);
    @(negedge clk);
    chk("sc_next_addr", bus.imem_addr, 8'h01);

    // Random traffic, model-checked every cycle
    for (int c = 0; c < 2000; c++) begin
      rst               = ($urandom_range(0, 99) == 0);
      bus.start         = ($urandom_range(0, 3) == 0);
      bus.halt_req      = ($urandom_range(0, 9) == 0);
      bus.imem_ack      = ($urandom_range(0, 1) == 0);
      bus.instr_ready   = ($urandom_range(0, 2) != 0);
      bus.branch_taken  = ($urandom_range(0, 3) == 0);
      bus.branch_target = 8'($urandom);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
